// File: rtl/uart_tx_frame_if.sv
// Parallel request side and serial/busy status of the UART frame transmitter.
// Handshake: a word is taken on the rising clk edge where DATA_VALID=1 and busy=0.
// busy is the inverse of ready. While busy=1, DATA_VALID and its payload are ignored.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  busy
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: one start bit, DATA_WIDTH data bits sent LSB first, an optional parity bit, and the stop bits.
// Each bit lasts one clk cycle. TX_OUT and busy are driven directly from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  tx_if,
  output logic [2:0]      dbg_state
);

  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam int STOP_N = (STOP_BITS == 2) ? 2 : 1;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_N - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en_q;
  logic                  par_bit;
  logic                  tx_q;
  logic                  busy_q;

  // Each output flop is loaded with the bit the next state drives onto the line.
  // Bit 0 of the data word is loaded on the START->DATA edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          bit_cnt <= '0;
          if (tx_if.DATA_VALID) begin
            state    <= START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            shreg    <= tx_if.P_DATA;
            par_en_q <= tx_if.PAR_EN;
            par_bit  <= (^tx_if.P_DATA) ^ tx_if.PAR_TYP;
          end
        end
        START: begin
          state   <= DATA;
          tx_q    <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt <= '0;
            if (par_en_q) begin
              state <= PARITY;
              tx_q  <= par_bit;
            end else begin
              state <= STOP;
              tx_q  <= 1'b1;
            end
          end else begin
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          state   <= STOP;
          tx_q    <= 1'b1;
          bit_cnt <= '0;
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_cnt == STOP_LAST) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign tx_if.TX_OUT = tx_q;
  assign tx_if.busy   = busy_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame. Directed frames go into a queue of expected bit patterns.
// A line monitor captures each frame starting at its start bit and checks it against the queue.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_WIDTH(8)) if1 ();
  uart_tx_frame_if #(.DATA_WIDTH(8)) if2 ();
  logic [2:0] dbg1, dbg2;

  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_if(if1), .dbg_state(dbg1)
  );
  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_if(if2), .dbg_state(dbg2)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int          len_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor
  logic        mon_active = 1'b0;
  logic        mon_post   = 1'b0;
  logic        mon_busy_ok;
  logic [15:0] mon_bits, mon_exp;
  int          mon_idx, mon_len;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      mon_post   = 1'b0;
    end else if (mon_post) begin
      check("idle_after_frame", {30'd0, if1.busy, if1.TX_OUT}, 32'd1);
      mon_post = 1'b0;
    end else begin
      if (!mon_active && if1.TX_OUT === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start bit with empty queue at %0t", $time);
        end else begin
          mon_exp     = exp_q.pop_front();
          mon_len     = len_q.pop_front();
          mon_active  = 1'b1;
          mon_idx     = 0;
          mon_bits    = '0;
          mon_busy_ok = 1'b1;
        end
      end
      if (mon_active) begin
        mon_bits[mon_idx] = if1.TX_OUT;
        if (if1.busy !== 1'b1) mon_busy_ok = 1'b0;
        mon_idx++;
        if (mon_idx == mon_len) begin
          check("frame_bits", {16'd0, mon_bits}, {16'd0, mon_exp});
          check("busy_during_frame", {31'd0, mon_busy_ok}, 32'd1);
          mon_active = 1'b0;
          mon_post   = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [15:0] frame, input int len);
    @(negedge clk);
    exp_q.push_back(frame);
    len_q.push_back(len);
    if1.P_DATA     = d;
    if1.PAR_EN     = pe;
    if1.PAR_TYP    = pt;
    if1.DATA_VALID = 1'b1;
    @(negedge clk);
    if1.DATA_VALID = 1'b0;
    if1.P_DATA     = ~d;
    if1.PAR_EN     = ~pe;
    if1.PAR_TYP    = ~pt;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((if1.busy || mon_active || mon_post) && n < 200);
    check("wait_idle_timeout", {31'd0, (n >= 200)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    if1.P_DATA = '0; if1.DATA_VALID = 1'b0; if1.PAR_EN = 1'b0; if1.PAR_TYP = 1'b0;
    if2.P_DATA = '0; if2.DATA_VALID = 1'b0; if2.PAR_EN = 1'b0; if2.PAR_TYP = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_tx", {31'd0, if1.TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, if1.busy}, 32'd0);
    check("reset_state", {29'd0, dbg1}, 32'd0);

    // A5 without parity, then with even and odd parity
    send(8'hA5, 1'b0, 1'b0, 16'h034A, 10); wait_idle();
    send(8'hA5, 1'b1, 1'b0, 16'h054A, 11); wait_idle();
    send(8'hA5, 1'b1, 1'b1, 16'h074A, 11); wait_idle();
    // 07 with even parity: three ones, so the parity bit is 1
    send(8'h07, 1'b1, 1'b0, 16'h060E, 11); wait_idle();

    // DATA_VALID held high while the word changes every cycle; an accept happens every 11 cycles
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      d = 8'(c * 37 + 5);
      if1.P_DATA     = d;
      if1.PAR_EN     = 1'b0;
      if1.PAR_TYP    = 1'b0;
      if1.DATA_VALID = 1'b1;
      if (c % 11 == 0) begin
        exp_q.push_back({7'd0, 1'b1, d, 1'b0});
        len_q.push_back(10);
      end
    end
    @(negedge clk);
    if1.DATA_VALID = 1'b0;
    wait_idle();

    // Reset during data bit 3; that frame is abandoned
    @(negedge clk);
    exp_q.push_back(16'h034A);
    len_q.push_back(10);
    if1.P_DATA = 8'hA5; if1.PAR_EN = 1'b0; if1.DATA_VALID = 1'b1;
    @(negedge clk);
    if1.DATA_VALID = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, if1.TX_OUT}, 32'd1);
    check("async_rst_busy", {31'd0, if1.busy}, 32'd0);
    check("async_rst_state", {29'd0, dbg1}, 32'd0);
    check("abandoned_popped", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    send(8'h3C, 1'b1, 1'b1, 16'h0678, 11); wait_idle();

    // Two stop bits: FF without parity gives the start bit, then 10 high cycles
    @(negedge clk);
    if2.P_DATA = 8'hFF; if2.PAR_EN = 1'b0; if2.PAR_TYP = 1'b0; if2.DATA_VALID = 1'b1;
    @(negedge clk);
    if2.DATA_VALID = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      check("stop2_tx", {31'd0, if2.TX_OUT}, (i == 0) ? 32'd0 : 32'd1);
      check("stop2_busy", {31'd0, if2.busy}, (i < 11) ? 32'd1 : 32'd0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
